// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dmem_wait,
  input  logic             mispredict_e,
  input  logic             ld_e,
  input  logic [4:0]       rd_addr_e,
  input  logic [4:0]       rs1_addr_d,
  input  logic [4:0]       rs2_addr_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic             mc_start_e,
  input  logic             mc_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             redirect_o,
  output logic             btb_update_en,
  output logic [1:0]       ctrl_state,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  localparam int MCW = $clog2(MC_TIMEOUT + 1);
  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [MCW-1:0] MC_MAX = MCW'(MC_TIMEOUT);

  state_t         state_q, state_d;
  logic [2:0]     fl_q, fl_d;
  logic [MCW-1:0] mc_q, mc_d;
  logic           err_q, err_d;
  logic           ld_use;

  assign ld_use = ld_e && (rd_addr_e != 5'd0) &&
                  ((rs1_used_d && (rd_addr_e == rs1_addr_d)) ||
                   (rs2_used_d && (rd_addr_e == rs2_addr_d)));

  assign ctrl_state = state_q;
  assign err_o      = err_q;

  // Next state and Mealy stage controls; freeze holds everything.
  always_comb begin
    state_d       = state_q;
    fl_d          = fl_q;
    mc_d          = mc_q;
    err_d         = err_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    redirect_o    = 1'b0;
    btb_update_en = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (dmem_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mispredict_e) begin
            redirect_o    = 1'b1;
            btb_update_en = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fl_d    = FL_INIT;
            end
          end else if (mc_start_e) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            state_d      = MC_WAIT;
            mc_d         = MCW'(1);
          end else if (ld_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          fl_d        = fl_q - 3'd1;
          if (fl_q <= 3'd1) begin
            state_d = RUN;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_d = RUN;
            mc_d    = '0;
          end else if (mc_q >= MC_MAX) begin
            state_d = RUN;
            mc_d    = '0;
            err_d   = 1'b1;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            mc_d         = mc_q + MCW'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Registered FSM state, window counters and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      fl_q    <= '0;
      mc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      mc_q    <= mc_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // Saturating counts of stalled-PC cycles and redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (redirect_o && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl.
// Reference model tracks flush window and mc wait age.
module tb_pipe_hazard_ctrl;

  localparam int FC = 3;
  localparam int TO = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dmem_wait;
  logic          mispredict_e;
  logic          ld_e;
  logic [4:0]    rd_addr_e;
  logic [4:0]    rs1_addr_d;
  logic [4:0]    rs2_addr_d;
  logic          rs1_used_d;
  logic          rs2_used_d;
  logic          mc_start_e;
  logic          mc_done;
  logic          pc_en;
  logic          if_id_en;
  logic          id_ex_en;
  logic          ex_mem_en;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          ex_mem_flush;
  logic          redirect_o;
  logic          btb_update_en;
  logic [1:0]    ctrl_state;
  logic          err_o;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int n_chk = 0;
  int n_bad = 0;

  int     flush_left = 0;
  bit     in_mc = 0;
  int     mc_age = 0;
  bit     m_err = 0;
  longint m_stall = 0;
  longint m_flush = 0;
  longint cmax = (longint'(1) << CW) - 1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .MC_TIMEOUT  (TO),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_wait    (dmem_wait),
    .mispredict_e (mispredict_e),
    .ld_e         (ld_e),
    .rd_addr_e    (rd_addr_e),
    .rs1_addr_d   (rs1_addr_d),
    .rs2_addr_d   (rs2_addr_d),
    .rs1_used_d   (rs1_used_d),
    .rs2_used_d   (rs2_used_d),
    .mc_start_e   (mc_start_e),
    .mc_done      (mc_done),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .redirect_o   (redirect_o),
    .btb_update_en(btb_update_en),
    .ctrl_state   (ctrl_state),
    .err_o        (err_o),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    dmem_wait    = 1'b0;
    mispredict_e = 1'b0;
    ld_e         = 1'b0;
    rd_addr_e    = 5'd0;
    rs1_addr_d   = 5'd0;
    rs2_addr_d   = 5'd0;
    rs1_used_d   = 1'b0;
    rs2_used_d   = 1'b0;
    mc_start_e   = 1'b0;
    mc_done      = 1'b0;
  endtask

  task automatic model_eval(output logic [8:0] eo, output logic [1:0] es);
    logic pc, fe, de, xe, ff, df, xf, rd, bt, hz;
    {pc, fe, de, xe} = 4'b1111;
    {ff, df, xf, rd, bt} = 5'b0;
    es = (flush_left > 0) ? 2'd1 : (in_mc ? 2'd2 : 2'd0);
    hz = ld_e && (rd_addr_e != 5'd0) &&
         ((rs1_used_d && rd_addr_e == rs1_addr_d) ||
          (rs2_used_d && rd_addr_e == rs2_addr_d));
    if (!rst_n) begin
      {pc, fe, de, xe} = 4'b0;
      {ff, df, xf} = 3'b111;
    end else if (dmem_wait) begin
      {pc, fe, de, xe} = 4'b0;
    end else if (flush_left > 0) begin
      {ff, df} = 2'b11;
    end else if (in_mc) begin
      if (!mc_done && mc_age < TO) begin
        {pc, fe, de} = 3'b0;
        xf = 1'b1;
      end
    end else if (mispredict_e) begin
      {rd, bt, ff, df} = 4'b1111;
    end else if (mc_start_e) begin
      {pc, fe, de} = 3'b0;
      xf = 1'b1;
    end else if (hz) begin
      pc = 1'b0;
      fe = 1'b0;
      df = 1'b1;
    end
    eo = {pc, fe, de, xe, ff, df, xf, rd, bt};
  endtask

  task automatic model_update(input logic [8:0] eo);
    if (!rst_n) begin
      flush_left = 0;
      in_mc = 0;
      mc_age = 0;
      m_err = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!eo[8] && m_stall < cmax) m_stall++;
      if (eo[1] && m_flush < cmax) m_flush++;
      if (!dmem_wait) begin
        if (flush_left > 0) begin
          flush_left--;
        end else if (in_mc) begin
          if (mc_done) in_mc = 0;
          else if (mc_age >= TO) begin
            in_mc = 0;
            m_err = 1;
          end else mc_age++;
        end else if (mispredict_e) begin
          flush_left = FC - 1;
        end else if (mc_start_e) begin
          in_mc = 1;
          mc_age = 1;
        end
      end
    end
  endtask

  task automatic step();
    logic [8:0] eo;
    logic [1:0] es;
    longint     xs, xf;
    model_eval(eo, es);
`ifdef HAZARD_PERF_CNT_EN
    xs = m_stall;
    xf = m_flush;
`else
    xs = 0;
    xf = 0;
`endif
    #1;
    chk("ctl", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
                    id_ex_flush, ex_mem_flush, redirect_o,
                    btb_update_en}), 64'(eo));
    chk("state", 64'(ctrl_state), 64'(es));
    chk("err", 64'(err_o), 64'(m_err));
    chk("stall_cnt", 64'(stall_cnt), 64'(xs));
    chk("flush_cnt", 64'(flush_cnt), 64'(xf));
    @(posedge clk);
    model_update(eo);
    @(negedge clk);
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();
    // load-use on rs1, then the x0 and rs2 variants
    ld_e = 1'b1; rd_addr_e = 5'd5; rs1_addr_d = 5'd5; rs1_used_d = 1'b1;
    step();
    idle_in();
    step();
    ld_e = 1'b1; rd_addr_e = 5'd0; rs1_addr_d = 5'd0; rs1_used_d = 1'b1;
    step();
    ld_e = 1'b1; rd_addr_e = 5'd7; rs2_addr_d = 5'd7; rs2_used_d = 1'b1;
    step();
    idle_in();
    // mispredict flush window
    mispredict_e = 1'b1;
    step();
    step();
    mispredict_e = 1'b0;
    repeat (3) step();
    // multi-cycle op finishing in time
    mc_start_e = 1'b1; mc_done = 1'b1;
    step();
    mc_start_e = 1'b0; mc_done = 1'b0;
    repeat (2) step();
    mc_done = 1'b1;
    step();
    idle_in();
    step();
    // multi-cycle op timing out
    mc_start_e = 1'b1;
    step();
    mc_start_e = 1'b0;
    repeat (6) step();
    // everything at once under freeze
    dmem_wait = 1'b1; mispredict_e = 1'b1; mc_start_e = 1'b1;
    ld_e = 1'b1; rd_addr_e = 5'd3; rs1_addr_d = 5'd3; rs1_used_d = 1'b1;
    repeat (3) step();
    dmem_wait = 1'b0;
    step();
    idle_in();
    repeat (3) step();
    // reset in the middle of MC_WAIT
    mc_start_e = 1'b1;
    step();
    mc_start_e = 1'b0;
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      dmem_wait    = ($urandom_range(0, 6) == 0);
      mispredict_e = ($urandom_range(0, 7) == 0);
      mc_start_e   = ($urandom_range(0, 7) == 0);
      mc_done      = ($urandom_range(0, 3) == 0);
      ld_e         = $urandom_range(0, 1) == 1;
      rd_addr_e    = 5'($urandom_range(0, 3));
      rs1_addr_d   = 5'($urandom_range(0, 3));
      rs2_addr_d   = 5'($urandom_range(0, 3));
      rs1_used_d   = $urandom_range(0, 1) == 1;
      rs2_used_d   = $urandom_range(0, 1) == 1;
      step();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Inputs: branch mispredict from EX, load-use hazards between EX and ID, multi-cycle EX ops (mul/div), data-memory wait.
- Produces per-stage enables/flushes, PC redirect and BTB update strobes.
- A small FSM handles multi-cycle flush windows and multi-cycle EX ops, with a watchdog.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID+ID/EX are flushed after a mispredict (min 1, max 7).
- MC_TIMEOUT, 64, max cycles in MC_WAIT before forced exit (>=2).
- CNT_W, 32, perf counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- dmem_wait  in  1  data memory not ready; global freeze.
- mispredict_e  in  1  EX branch outcome differs from prediction.
- ld_e  in  1  EX instruction is a load.
- rd_addr_e  in  5  EX destination register.
- rs1_addr_d  in  5  ID source register 1.
- rs2_addr_d  in  5  ID source register 2.
- rs1_used_d  in  1  ID instruction reads rs1.
- rs2_used_d  in  1  ID instruction reads rs2.
- mc_start_e  in  1  multi-cycle op present in EX (first cycle).
- mc_done  in  1  multi-cycle unit result valid.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID enable.
- id_ex_en  out  1  ID/EX enable.
- ex_mem_en  out  1  EX/MEM enable.
- if_id_flush  out  1  IF/ID clear to NOP.
- id_ex_flush  out  1  ID/EX clear to NOP.
- ex_mem_flush  out  1  EX/MEM clear to NOP.
- redirect_o  out  1  PC mux selects corrected target.
- btb_update_en  out  1  BTB/predictor write strobe.
- ctrl_state  out  2  FSM state: 0 RUN, 1 FLUSH, 2 MC_WAIT.
- err_o  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  cycles with pc_en=0 (optional feature).
- flush_cnt  out  CNT_W  mispredict events (optional feature).

Behaviour:
- Outputs are combinational from state and inputs (Mealy). State, counters and err_o are registered.
- Reset (rst_n=0, sampled at clk):
  - state -> RUN; flush counter, MC counter, err_o and perf counters -> 0.
  - While rst_n=0: all *_en=0, all *_flush=1, redirect_o=0, btb_update_en=0.
- Default when no event: all *_en=1, all *_flush=0, redirect_o=0, btb_update_en=0.
- Global freeze, highest priority, any state, dmem_wait=1:
  - All *_en=0, all *_flush=0, redirect_o=0, btb_update_en=0.
  - FSM and internal counters hold. Events are re-evaluated when dmem_wait drops.
- RUN priority: mispredict_e > mc_start_e > load-use.
- Mispredict:
  - redirect_o=1, btb_update_en=1, pc_en=1, if_id_flush=1, id_ex_flush=1. EX/MEM is not flushed.
  - FLUSH_CYCLES=1: remain RUN. Otherwise go to FLUSH with counter = FLUSH_CYCLES-1.
- FLUSH:
  - if_id_flush=1, id_ex_flush=1, pc_en=1, redirect_o=0.
  - Counter decrements each non-frozen cycle; at 1 -> RUN.
  - A mispredict_e in FLUSH is ignored (EX holds a bubble).
- Multi-cycle op (mc_start_e in RUN, no mispredict):
  - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1 (bubble into MEM).
  - Go to MC_WAIT with MC counter = 1. mc_start_e is ignored in all other states.
- MC_WAIT:
  - Same outputs as the multi-cycle op cycle while mc_done=0. MC counter increments each non-frozen cycle.
  - mc_done=1: default outputs that cycle, -> RUN.
  - Counter reaching MC_TIMEOUT with mc_done=0: default outputs, err_o<=1, -> RUN.
  - mc_done in the same cycle as entry is ignored (unit latency >= 1).
- Load-use (RUN only):
  - Condition: ld_e && rd_addr_e!=0 && ((rs1_used_d && rd_addr_e==rs1_addr_d) || (rs2_used_d && rd_addr_e==rs2_addr_d)).
  - pc_en=if_id_en=0, id_ex_flush=1 for exactly that cycle; stay RUN.
- err_o clears only on reset.
- ctrl_state reflects the registered state.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every non-reset cycle with pc_en=0, freeze cycles included.
  - flush_cnt increments on each cycle with redirect_o=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: counters are not instantiated; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 (rs1_used_d=1) -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle defaults. Same stimulus with rd_addr_e=0 -> no stall.
- FLUSH_CYCLES=3, mispredict_e pulse -> cycle0: redirect_o=1, btb_update_en=1; cycles1-2: ctrl_state=1, if_id_flush=id_ex_flush=1; cycle3: RUN. With the macro defined, flush_cnt=1.
- mc_start_e, mc_done after 5 cycles -> 5 cycles with pc_en=0, ex_mem_flush=1, ctrl_state=2; mc_done cycle shows defaults; err_o stays 0.
- MC_TIMEOUT=4, mc_done never asserted -> exit to RUN after 4 MC_WAIT cycles, err_o=1 held until rst_n=0.
- mispredict_e and mc_start_e and load-use together with dmem_wait=1 for 3 cycles -> 3 frozen cycles with all enables 0 and no flush. Then mispredict handling, and mc_start_e ignored.
- rst_n=0 mid-MC_WAIT -> next edge ctrl_state=0, err_o=0, counters 0; during reset all *_flush=1 and all *_en=0.
